// File: rtl/aes_io_pkg.sv
// Shared types and handshake codes for the AES PIO bridge.
package aes_io_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACK_HDR,
    ST_WAIT_MSG,
    ST_ACK_MSG,
    ST_WAIT_KEY,
    ST_ACK_KEY,
    ST_START,
    ST_RUN,
    ST_SEND,
    ST_SEND_CLR
  } state_t;

  localparam logic [1:0] HS_IDLE  = 2'b00;
  localparam logic [1:0] HS_VALID = 2'b01;
  localparam logic [1:0] HS_ACK   = 2'b10;
  localparam logic [1:0] HS_ABORT = 2'b11;

endpackage

// File: rtl/aes_io_bridge_word_shift_reg.sv
// Load-enable shift-in register: each load pushes one word in at the bottom,
// so the first word loaded ends up in the top slice after BLOCK_W/PORT_W loads.
module word_shift_reg #(
  parameter int PORT_W  = 32,
  parameter int BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [PORT_W-1:0]  i_word,
  output logic [BLOCK_W-1:0] o_q
);

  logic [BLOCK_W-1:0] r_q;
  logic [BLOCK_W-1:0] w_next;

  if (BLOCK_W == PORT_W) begin : g_single
    assign w_next = i_word;
  end else begin : g_multi
    assign w_next = {r_q[BLOCK_W-PORT_W-1:0], i_word};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/aes_io_bridge.sv
// PIO handshake bridge to an AES core: header, message and key in, result out.
// Outputs are registered from the next state so they track the state entered.
module aes_io_bridge
  import aes_io_pkg::*;
#(
  parameter int PORT_W  = 32,
  parameter int BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         to_hw_sig,
  input  logic [PORT_W-1:0]  to_hw_port,
  output logic [1:0]         to_sw_sig,
  output logic [PORT_W-1:0]  to_sw_port,
  output logic               core_start,
  output logic               core_mode,
  output logic [BLOCK_W-1:0] core_din,
  output logic [BLOCK_W-1:0] core_key,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_dout,
  output logic               busy
);

  localparam int WORDS = BLOCK_W / PORT_W;
  localparam int CNT_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_IN_DONE  = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_OUT_LAST = CNT_W'(WORDS - 1);

  if (BLOCK_W % PORT_W != 0) begin : g_width_check
    $error("aes_io_bridge: BLOCK_W must be a multiple of PORT_W");
  end

  state_t             r_state, w_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_mode, w_mode_nxt;
  logic [BLOCK_W-1:0] r_result, w_res_nxt;
  logic               w_ld_msg, w_ld_key;
  logic [PORT_W-1:0]  w_slice;
  logic [1:0]         r_sw_sig;
  logic [PORT_W-1:0]  r_sw_port;
  logic               r_start;
  logic               r_busy;

  always_comb begin
    w_nxt      = r_state;
    w_cnt_nxt  = r_cnt;
    w_mode_nxt = r_mode;
    w_res_nxt  = r_result;
    w_ld_msg   = 1'b0;
    w_ld_key   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (to_hw_sig == HS_VALID) begin
          w_mode_nxt = to_hw_port[0];
          w_nxt      = ST_ACK_HDR;
        end
      end
      ST_ACK_HDR: begin
        if (to_hw_sig == HS_IDLE) w_nxt = ST_WAIT_MSG;
      end
      ST_WAIT_MSG: begin
        if (to_hw_sig == HS_VALID) begin
          w_ld_msg  = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_nxt     = ST_ACK_MSG;
        end
      end
      ST_ACK_MSG: begin
        if (to_hw_sig == HS_IDLE) begin
          if (r_cnt == CNT_IN_DONE) begin
            w_cnt_nxt = '0;
            w_nxt     = ST_WAIT_KEY;
          end else begin
            w_nxt = ST_WAIT_MSG;
          end
        end
      end
      ST_WAIT_KEY: begin
        if (to_hw_sig == HS_VALID) begin
          w_ld_key  = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_nxt     = ST_ACK_KEY;
        end
      end
      ST_ACK_KEY: begin
        if (to_hw_sig == HS_IDLE) begin
          if (r_cnt == CNT_IN_DONE) begin
            w_cnt_nxt = '0;
            w_nxt     = ST_START;
          end else begin
            w_nxt = ST_WAIT_KEY;
          end
        end
      end
      ST_START: w_nxt = ST_RUN;
      ST_RUN: begin
        if (core_done) begin
          w_res_nxt = core_dout;
          w_cnt_nxt = '0;
          w_nxt     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (to_hw_sig == HS_ACK) w_nxt = ST_SEND_CLR;
      end
      ST_SEND_CLR: begin
        if (to_hw_sig == HS_IDLE) begin
          if (r_cnt == CNT_OUT_LAST) begin
            w_cnt_nxt = '0;
            w_nxt     = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            w_nxt     = ST_SEND;
          end
        end
      end
      default: w_nxt = ST_IDLE;
    endcase

    // Abort drops the operation but keeps the operands and last result.
    if (r_state != ST_IDLE && to_hw_sig == HS_ABORT) begin
      w_nxt     = ST_IDLE;
      w_cnt_nxt = '0;
      w_res_nxt = r_result;
      w_ld_msg  = 1'b0;
      w_ld_key  = 1'b0;
    end
  end

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (w_cnt_nxt == CNT_W'(i)) w_slice = w_res_nxt[BLOCK_W-1-i*PORT_W -: PORT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_result  <= '0;
      r_sw_sig  <= HS_IDLE;
      r_sw_port <= '0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mode   <= w_mode_nxt;
      r_result <= w_res_nxt;
      case (w_nxt)
        ST_ACK_HDR, ST_ACK_MSG, ST_ACK_KEY: r_sw_sig <= HS_ACK;
        ST_SEND:                            r_sw_sig <= HS_VALID;
        default:                            r_sw_sig <= HS_IDLE;
      endcase
      if (w_nxt == ST_SEND) r_sw_port <= w_slice;
      r_start <= (w_nxt == ST_START);
      r_busy  <= (w_nxt != ST_IDLE);
    end
  end

  word_shift_reg #(.PORT_W(PORT_W), .BLOCK_W(BLOCK_W)) u_msg_reg (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_ld_msg),
    .i_word (to_hw_port),
    .o_q    (core_din)
  );

  word_shift_reg #(.PORT_W(PORT_W), .BLOCK_W(BLOCK_W)) u_key_reg (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_ld_key),
    .i_word (to_hw_port),
    .o_q    (core_key)
  );

  assign to_sw_sig  = r_sw_sig;
  assign to_sw_port = r_sw_port;
  assign core_start = r_start;
  assign core_mode  = r_mode;
  assign busy       = r_busy;

endmodule

// File: tb/tb_aes_io_bridge.sv
// Bench for aes_io_bridge at BLOCK_W 128, 64 and 32 with PORT_W 32, acting as
// software on the PIO side and as a stub AES core on the other.
module tb_aes_io_bridge;
  import aes_io_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [1:0]   hw_sig  [3];
  logic [31:0]  hw_port [3];
  logic         done    [3];
  logic [127:0] dout0;
  logic [63:0]  dout1;
  logic [31:0]  dout2;

  wire [1:0]   sw_sig  [3];
  wire [31:0]  sw_port [3];
  wire         start   [3];
  wire         mode    [3];
  wire         busy    [3];
  wire [127:0] din0, key0;
  wire [63:0]  din1, key1;
  wire [31:0]  din2, key2;
  wire [127:0] din_v [3];
  wire [127:0] key_v [3];

  assign din_v[0] = din0;
  assign din_v[1] = {64'd0, din1};
  assign din_v[2] = {96'd0, din2};
  assign key_v[0] = key0;
  assign key_v[1] = {64'd0, key1};
  assign key_v[2] = {96'd0, key2};

  aes_io_bridge #(.PORT_W(32), .BLOCK_W(128)) u_dut0 (
    .clk(clk), .reset(reset), .to_hw_sig(hw_sig[0]), .to_hw_port(hw_port[0]),
    .to_sw_sig(sw_sig[0]), .to_sw_port(sw_port[0]), .core_start(start[0]),
    .core_mode(mode[0]), .core_din(din0), .core_key(key0), .core_done(done[0]),
    .core_dout(dout0), .busy(busy[0]));

  aes_io_bridge #(.PORT_W(32), .BLOCK_W(64)) u_dut1 (
    .clk(clk), .reset(reset), .to_hw_sig(hw_sig[1]), .to_hw_port(hw_port[1]),
    .to_sw_sig(sw_sig[1]), .to_sw_port(sw_port[1]), .core_start(start[1]),
    .core_mode(mode[1]), .core_din(din1), .core_key(key1), .core_done(done[1]),
    .core_dout(dout1), .busy(busy[1]));

  aes_io_bridge #(.PORT_W(32), .BLOCK_W(32)) u_dut2 (
    .clk(clk), .reset(reset), .to_hw_sig(hw_sig[2]), .to_hw_port(hw_port[2]),
    .to_sw_sig(sw_sig[2]), .to_sw_port(sw_port[2]), .core_start(start[2]),
    .core_mode(mode[2]), .core_din(din2), .core_key(key2), .core_done(done[2]),
    .core_dout(dout2), .busy(busy[2]));

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt [3];

  initial for (int d = 0; d < 3; d++) start_cnt[d] = 0;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) if (start[d] === 1'b1) start_cnt[d] <= start_cnt[d] + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: operands are the words read as one big-endian number.
  function automatic int wd(int d);
    return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
  endfunction

  function automatic logic [127:0] mask_of(int w);
    logic [127:0] one;
    one = 128'd1;
    return (w == 4) ? {128{1'b1}} : ((one << (32 * w)) - one);
  endfunction

  function automatic logic [31:0] word_of(logic [127:0] v, int w, int i);
    logic [127:0] t;
    t = v >> (32 * (w - 1 - i));
    return t[31:0];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_dout(int d, logic [127:0] v);
    case (d)
      0: dout0 = v;
      1: dout1 = v[63:0];
      default: dout2 = v[31:0];
    endcase
  endtask

  task automatic sw_write(int d, logic [31:0] w);
    int n;
    @(negedge clk);
    hw_port[d] = w;
    hw_sig[d]  = HS_VALID;
    n = 0;
    do begin @(negedge clk); n++; end while (sw_sig[d] !== HS_ACK && n < 20);
    chk("ack_latency", 128'(n), 128'd1);
    hw_sig[d] = HS_IDLE;
    n = 0;
    do begin @(negedge clk); n++; end while (sw_sig[d] !== HS_IDLE && n < 20);
    chk("ack_release", 128'(n), 128'd1);
  endtask

  task automatic sw_read(int d, logic m, output logic [31:0] w);
    int n;
    n = 0;
    while (sw_sig[d] !== HS_VALID && n < 20) begin @(negedge clk); n++; end
    w = sw_port[d];
    chk("mode_hold", 128'(mode[d]), 128'(m));
    chk("busy_send", 128'(busy[d]), 128'd1);
    hw_sig[d] = HS_ACK;
    n = 0;
    do begin @(negedge clk); n++; end while (sw_sig[d] !== HS_IDLE && n < 20);
    chk("valid_release", 128'(n), 128'd1);
    hw_sig[d] = HS_IDLE;
  endtask

  task automatic pulse_done(int d, logic [127:0] res);
    done[d] = 1'b1;
    set_dout(d, res);
    @(negedge clk);
    done[d] = 1'b0;
    set_dout(d, rnd128());
  endtask

  // Ends on the cycle after the start pulse, with the DUT waiting in RUN.
  task automatic load_op(int d, logic m, logic [127:0] msg, logic [127:0] key);
    int w  = wd(d);
    int s0 = start_cnt[d];
    sw_write(d, {31'd0, m});
    for (int i = 0; i < w; i++) sw_write(d, word_of(msg, w, i));
    for (int i = 0; i < w; i++) begin
      if (i == w - 1) chk("no_early_start", 128'(start_cnt[d] - s0), 128'd0);
      sw_write(d, word_of(key, w, i));
    end
    chk("start_pulse", 128'(start[d]), 128'd1);
    chk("core_din", din_v[d], msg & mask_of(w));
    chk("core_key", key_v[d], key & mask_of(w));
    chk("core_mode", 128'(mode[d]), 128'(m));
    @(negedge clk);
    chk("start_width", 128'(start[d]), 128'd0);
  endtask

  task automatic run_op(int d, logic m, logic [127:0] msg, logic [127:0] key, logic [127:0] res);
    int w  = wd(d);
    int s0 = start_cnt[d];
    logic [31:0] rw;
    load_op(d, m, msg, key);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    pulse_done(d, res);
    chk("result_latency", 128'(sw_sig[d]), 128'(HS_VALID));
    for (int i = 0; i < w; i++) begin
      sw_read(d, m, rw);
      chk("result_word", 128'(rw), 128'(word_of(res, w, i)));
    end
    @(negedge clk);
    chk("busy_end", 128'(busy[d]), 128'd0);
    chk("start_count", 128'(start_cnt[d] - s0), 128'd1);
  endtask

  typedef struct {
    int           d;
    logic         m;
    logic [127:0] msg;
    logic [127:0] key;
    logic [127:0] res;
  } vec_t;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  vec_t tbl [7];

  initial begin
    logic [31:0]  rw;
    logic [127:0] msg_a, key_a;
    int           s0, n;

    tbl[0] = '{0, 1'b0, FIPS_PT, FIPS_KEY, FIPS_CT};
    tbl[1] = '{0, 1'b1, FIPS_CT, FIPS_KEY, FIPS_PT};
    tbl[2] = '{0, 1'($urandom()), rnd128(), rnd128(), rnd128()};
    tbl[3] = '{1, 1'b0, 128'h0000000000000000_0123456789abcdef,
               128'h0000000000000000_fedcba9876543210,
               128'h0000000000000000_a1b2c3d4e5f60718};
    tbl[4] = '{1, 1'($urandom()), rnd128(), rnd128(), rnd128()};
    tbl[5] = '{2, 1'b1, 128'h000000000000000000000000deadbeef,
               128'h00000000000000000000000012345678,
               128'h000000000000000000000000cafef00d};
    tbl[6] = '{2, 1'($urandom()), rnd128(), rnd128(), rnd128()};

    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      hw_sig[d]  = HS_IDLE;
      hw_port[d] = '0;
      done[d]    = 1'b0;
    end
    dout0 = '0; dout1 = '0; dout2 = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_sw_sig", 128'(sw_sig[d]), 128'(HS_IDLE));
      chk("rst_sw_port", 128'(sw_port[d]), 128'd0);
      chk("rst_start", 128'(start[d]), 128'd0);
      chk("rst_mode", 128'(mode[d]), 128'd0);
      chk("rst_din", din_v[d], 128'd0);
      chk("rst_key", key_v[d], 128'd0);
      chk("rst_busy", 128'(busy[d]), 128'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++)
      run_op(tbl[v].d, tbl[v].m, tbl[v].msg, tbl[v].key, tbl[v].res);

    // Idle ignores ACK and ABORT.
    hw_sig[0] = HS_ACK;
    repeat (2) @(negedge clk);
    hw_sig[0] = HS_ABORT;
    repeat (2) @(negedge clk);
    chk("idle_ignore_sig", 128'(sw_sig[0]), 128'(HS_IDLE));
    chk("idle_ignore_busy", 128'(busy[0]), 128'd0);
    hw_sig[0] = HS_IDLE;
    @(negedge clk);

    // Abort while acknowledging key word 2.
    msg_a = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
    key_a = 128'h11111111_22222222_33333333_44444444;
    s0 = start_cnt[0];
    sw_write(0, 32'd1);
    for (int i = 0; i < 4; i++) sw_write(0, word_of(msg_a, 4, i));
    for (int i = 0; i < 2; i++) sw_write(0, word_of(key_a, 4, i));
    @(negedge clk);
    hw_port[0] = word_of(key_a, 4, 2);
    hw_sig[0]  = HS_VALID;
    @(negedge clk);
    chk("abort_key_ack", 128'(sw_sig[0]), 128'(HS_ACK));
    hw_sig[0] = HS_ABORT;
    @(negedge clk);
    chk("abort_key_sig", 128'(sw_sig[0]), 128'(HS_IDLE));
    chk("abort_key_busy", 128'(busy[0]), 128'd0);
    chk("abort_key_din_kept", din_v[0], msg_a);
    chk("abort_key_mode_kept", 128'(mode[0]), 128'd1);
    hw_sig[0] = HS_IDLE;
    repeat (3) @(negedge clk);
    chk("abort_key_no_start", 128'(start_cnt[0] - s0), 128'd0);
    run_op(0, 1'b0, FIPS_PT, FIPS_KEY, FIPS_CT);

    // Abort in RUN, then a late completion from the core.
    s0 = start_cnt[0];
    load_op(0, 1'b1, FIPS_CT, FIPS_KEY);
    hw_sig[0] = HS_ABORT;
    @(negedge clk);
    chk("abort_run_busy", 128'(busy[0]), 128'd0);
    chk("abort_run_sig", 128'(sw_sig[0]), 128'(HS_IDLE));
    hw_sig[0] = HS_IDLE;
    repeat (4) @(negedge clk);
    pulse_done(0, FIPS_PT);
    for (int i = 0; i < 3; i++) begin
      chk("late_done_sig", 128'(sw_sig[0]), 128'(HS_IDLE));
      chk("late_done_busy", 128'(busy[0]), 128'd0);
      @(negedge clk);
    end
    chk("abort_run_starts", 128'(start_cnt[0] - s0), 128'd1);

    // Reset while word 1 of the result is on offer.
    load_op(0, 1'b1, FIPS_CT, FIPS_KEY);
    pulse_done(0, FIPS_PT);
    sw_read(0, 1'b1, rw);
    chk("pre_reset_word0", 128'(rw), 128'(word_of(FIPS_PT, 4, 0)));
    n = 0;
    while (sw_sig[0] !== HS_VALID && n < 20) begin @(negedge clk); n++; end
    chk("pre_reset_word1", 128'(sw_port[0]), 128'(word_of(FIPS_PT, 4, 1)));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_sw_sig", 128'(sw_sig[0]), 128'(HS_IDLE));
    chk("mid_rst_sw_port", 128'(sw_port[0]), 128'd0);
    chk("mid_rst_start", 128'(start[0]), 128'd0);
    chk("mid_rst_mode", 128'(mode[0]), 128'd0);
    chk("mid_rst_din", din_v[0], 128'd0);
    chk("mid_rst_key", key_v[0], 128'd0);
    chk("mid_rst_busy", 128'(busy[0]), 128'd0);
    reset = 1'b0;
    hw_sig[0] = HS_ACK;
    repeat (3) @(negedge clk);
    chk("post_rst_ack_sig", 128'(sw_sig[0]), 128'(HS_IDLE));
    chk("post_rst_ack_busy", 128'(busy[0]), 128'd0);
    hw_sig[0] = HS_IDLE;
    @(negedge clk);
    run_op(0, 1'b0, tbl[2].msg, tbl[2].key, tbl[2].res);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_io_bridge.md
# aes_io_bridge

Parametrised software/hardware transfer engine between the Nios II PIO handshake ports and an AES core. Software sends a header word with the mode (encrypt or decrypt), then the message and key as PORT_W-bit words. The block assembles them into BLOCK_W-bit operands, pulses the core to start, captures the result and streams it back one word at a time. It generalises the fixed 128-bit io_module, adding:

- selectable width,
- per-operation mode,
- a start/done core handshake,
- software abort.

## Interface
Parameters:
- PORT_W, 32, PIO data word width
- BLOCK_W, 128, message/key/result width; BLOCK_W % PORT_W must be 0, otherwise elaboration fails via $error
- WORDS, BLOCK_W/PORT_W, derived localparam, not overridable

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- to_hw_sig  in  2  software handshake code
- to_hw_port  in  PORT_W  software data word
- to_sw_sig  out  2  hardware handshake code
- to_sw_port  out  PORT_W  result word to software
- core_start  out  1  one-cycle start pulse to AES core
- core_mode  out  1  0 = encrypt, 1 = decrypt; held from header until next header
- core_din  out  BLOCK_W  assembled message
- core_key  out  BLOCK_W  assembled key
- core_done  in  1  one-cycle completion pulse from core
- core_dout  in  BLOCK_W  core result, valid with core_done
- busy  out  1  high in every state except IDLE

## Operation
Handshake codes:
- HS_IDLE = 00
- HS_VALID = 01
- HS_ACK = 10
- HS_ABORT = 11

Word order: the first word transferred is bits [BLOCK_W-1 -: PORT_W]; later words fill successively lower slices.

States and transitions:
- IDLE: wait for to_hw_sig==HS_VALID. Latch to_hw_port[0] into core_mode, then go to ACK_HDR.
- ACK_HDR / ACK_MSG / ACK_KEY: drive to_sw_sig=HS_ACK; wait for to_hw_sig==HS_IDLE.
  - From ACK_HDR, go to WAIT_MSG.
  - From ACK_MSG, go to WAIT_MSG, or to WAIT_KEY after word WORDS-1.
  - From ACK_KEY, go to WAIT_KEY, or to START after word WORDS-1.
- WAIT_MSG / WAIT_KEY: on to_hw_sig==HS_VALID, shift to_hw_port into the core_din / core_key register and increment the word counter.
- START: core_start=1 for exactly one cycle, then go to RUN.
- RUN: wait for core_done. Capture core_dout into the result register, clear the counter, then go to SEND.
- SEND: to_sw_port = result slice[counter]; to_sw_sig=HS_VALID; on to_hw_sig==HS_ACK go to SEND_CLR.
- SEND_CLR: to_sw_sig=HS_IDLE; on to_hw_sig==HS_IDLE:
  - after word WORDS-1, go to IDLE;
  - otherwise increment the counter and return to SEND.

Boundary rules:
- to_hw_sig==HS_ABORT in any non-IDLE state: next state IDLE, counter cleared, to_sw_sig=00, core_start not issued.
  - core_din, core_key, core_mode and result retain their values.
- core_done outside RUN is ignored. This covers a late completion after an abort.
- In IDLE, HS_ACK and HS_ABORT are ignored.
- In a WAIT state, HS_ACK is ignored.
- Word counter width is $clog2(WORDS+1). It never wraps: it is cleared on every phase change.
- WORDS==1 is legal: each phase has exactly one word.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - to_sw_sig 00
  - to_sw_port 0
  - core_start 0
  - core_mode 0
  - core_din 0
  - core_key 0
  - busy 0
- Word latch: in the cycle to_hw_sig==HS_VALID is sampled. HS_ACK is visible the following cycle.
- HS_ACK drops the cycle after HS_IDLE is sampled.
- core_start is high exactly 1 cycle, 1 cycle after the final key ack is released. core_din and core_key are stable from that cycle until the next load.
- The first result word and HS_VALID appear 1 cycle after core_done is sampled.
- Reset mid-operation wins over every other event and returns all registers to their reset values.

## Structure
- Package aes_io_pkg holds:
  - typedef enum logic [3:0] state_t;
  - localparams HS_IDLE, HS_VALID, HS_ACK, HS_ABORT.
- Sub-module word_shift_reg #(PORT_W, BLOCK_W): load-enable shift-in register. It is instantiated twice, for core_din and core_key.

## Test plan
- Encrypt FIPS-197: header 0x0; msg 00112233_44556677_8899aabb_ccddeeff; key 00010203_04050607_08090a0b_0c0d0e0f.
  - Required: core_din and core_key match, core_mode=0, one core_start pulse.
  - Stub returns 69c4e0d8_6a7b0430_d8cdb780_70b4c55a; software reads those 4 words in that order; busy falls after the last ack.
- Decrypt: header 0x1.
  - Required: core_mode=1 held through SEND.
  - Stub result 00112233_... is returned word-by-word.
- Abort during ACK_KEY word 2 (to_hw_sig=11).
  - Required: IDLE next cycle, to_sw_sig=00, no core_start.
  - A subsequent full transfer works normally.
- Abort in RUN, then stub pulses core_done 5 cycles later.
  - Required: pulse ignored, to_sw_sig stays 00, busy=0.
- PORT_W=32, BLOCK_W=64 (WORDS=2) and BLOCK_W=32 (WORDS=1).
  - Required: correct word ordering; exactly 1+2·WORDS load transfers and WORDS result transfers.
- Reset asserted in SEND word 1.
  - Required: all outputs at reset values next cycle.
  - A spurious HS_ACK afterwards is ignored.
